// File: rtl/frac_lut6_cfg_loader.sv
// Configuration loader for a fracturable LUT6 cell.
// Receives a 10-byte frame: nine data bytes carry the 64-bit truth table, the
// 2-bit fracturing mode and six zero pad bits, and a tenth byte carries the
// XOR checksum. The frame is assembled in a shadow register. Only a fully
// validated frame is copied to the outputs, so the LUT never sees a partial
// configuration.
module frac_lut6_cfg_loader #(
    parameter int unsigned CHK_EN = 1
) (
    input  logic        prog_clk,
    input  logic        pReset,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_valid,
    input  logic        cfg_sof,
    output logic        cfg_ready,
    output logic [0:63] sram,
    output logic [0:63] sram_inv,
    output logic [0:1]  mode,
    output logic [0:1]  mode_inv,
    output logic        cfg_done,
    output logic        cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Frame check: pad bits must be zero and, when enabled, the checksum byte
    // must equal the XOR of the nine data bytes.
    function automatic logic frame_ok(input logic [0:71] shadow,
                                      input logic [7:0]  cks,
                                      input logic [7:0]  run_xor);
        logic pad_ok;
        logic cks_ok;
        pad_ok = (shadow[66:71] == 6'b000000);
        cks_ok = (CHK_EN == 0) || (cks == run_xor);
        return pad_ok && cks_ok;
    endfunction

    state_t        state_q,  state_d;
    logic [3:0]    cnt_q,    cnt_d;
    logic [7:0]    xor_q,    xor_d;
    logic [0:71]   shadow_q, shadow_d;
    logic [0:63]   sram_q,   sram_d;
    logic [0:63]   sram_inv_q;
    logic [0:1]    mode_q,   mode_d;
    logic [0:1]    mode_inv_q;
    logic          done_q,   done_d;
    logic          err_q,    err_d;
    logic          ready_s;
    logic          accept_s;

    // The loader stalls only for the single commit cycle. Ready is also held
    // low while reset is asserted, so it is 0 in the reset cycle and 1 in the
    // first cycle after reset.
    always_comb begin
        ready_s  = (state_q != ST_COMMIT) && !pReset;
        accept_s = cfg_valid && ready_s;
    end

    // Next-state logic: frame assembly, checksum tracking and commit control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        shadow_d = shadow_q;
        sram_d   = sram_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        err_d    = err_q;

        if (accept_s && cfg_sof) begin
            // An sof byte always restarts the frame, whatever the state.
            state_d  = ST_LOAD;
            cnt_d    = 4'd1;
            xor_d    = cfg_data;
            shadow_d = {64'h0, cfg_data};
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Non-sof bytes are accepted here and discarded.
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        if (cnt_q == 4'd9) begin
                            cnt_d = 4'd0;
                            xor_d = 8'h00;
                            if (frame_ok(shadow_q, cfg_data, xor_q)) begin
                                state_d = ST_COMMIT;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                err_d   = 1'b1;
                            end
                        end else begin
                            // Shift left so that byte 0 ends up in bits 0..7
                            // after nine bytes, MSB first.
                            shadow_d = {shadow_q[8:71], cfg_data};
                            xor_d    = xor_q ^ cfg_data;
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_COMMIT: begin
                    sram_d  = shadow_q[0:63];
                    mode_d  = shadow_q[64:65];
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State and output registers. The complement outputs load from the same
    // next-state value as the true outputs, so the two can never disagree.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            xor_q      <= 8'h00;
            shadow_q   <= 72'h0;
            sram_q     <= 64'h0;
            sram_inv_q <= {64{1'b1}};
            mode_q     <= 2'b00;
            mode_inv_q <= 2'b11;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            xor_q      <= xor_d;
            shadow_q   <= shadow_d;
            sram_q     <= sram_d;
            sram_inv_q <= ~sram_d;
            mode_q     <= mode_d;
            mode_inv_q <= ~mode_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready = ready_s;
    assign sram      = sram_q;
    assign sram_inv  = sram_inv_q;
    assign mode      = mode_q;
    assign mode_inv  = mode_inv_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Directed bench for frac_lut6_cfg_loader. It covers good and bad frames, a
// mid-frame restart, gapped input, and reset in the middle of a frame.
module tb_frac_lut6_cfg_loader;

    logic        prog_clk;
    logic        pReset;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_sof;
    logic        cfg_ready;
    logic [0:63] sram;
    logic [0:63] sram_inv;
    logic [0:1]  mode;
    logic [0:1]  mode_inv;
    logic        cfg_done;
    logic        cfg_err;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rlow_cnt = 0;
    int exp_commits = 0;
    int d0;

    frac_lut6_cfg_loader #(.CHK_EN(1)) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_sof  (cfg_sof),
        .cfg_ready(cfg_ready),
        .sram     (sram),
        .sram_inv (sram_inv),
        .mode     (mode),
        .mode_inv (mode_inv),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Count done pulses and cycles with ready low, outside reset.
    always @(negedge prog_clk) begin
        if (pReset === 1'b0) begin
            if (cfg_done === 1'b1) done_cnt++;
            if (cfg_ready !== 1'b1) rlow_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        cfg_valid = 1'b0;
        cfg_sof   = 1'b0;
        repeat (n) begin
            @(posedge prog_clk);
            #1;
        end
    endtask

    // Present one byte and hold it until it is accepted at a clock edge.
    task automatic put(input logic [7:0] d, input logic s);
        int guard;
        guard     = 0;
        cfg_data  = d;
        cfg_sof   = s;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && guard < 20) begin
            @(posedge prog_clk);
            #1;
            guard++;
        end
        if (guard >= 20) chk("ready_timeout", 72'(guard), 72'd0);
        @(posedge prog_clk);
        #1;
        cfg_valid = 1'b0;
        cfg_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] dat, input logic [7:0] cks, input bit gaps);
        for (int k = 0; k < 9; k++) begin
            if (gaps) idle($urandom_range(0, 3));
            put(dat[71-8*k -: 8], (k == 0));
            if (k == 0) chk("err_clr_on_sof", 72'(cfg_err), 72'd0);
        end
        if (gaps) idle($urandom_range(0, 3));
        put(cks, 1'b0);
    endtask

    initial begin
        pReset    = 1'b1;
        cfg_data  = 8'h00;
        cfg_valid = 1'b0;
        cfg_sof   = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        // Reset values
        chk("rst_ready", 72'(cfg_ready), 72'd0);
        chk("rst_sram", 72'(sram), 72'h0);
        chk("rst_sram_inv", 72'(sram_inv), {8'h00, {64{1'b1}}});
        chk("rst_mode", 72'(mode), 72'd0);
        chk("rst_mode_inv", 72'(mode_inv), 72'd3);
        chk("rst_done", 72'(cfg_done), 72'd0);
        chk("rst_err", 72'(cfg_err), 72'd0);
        pReset = 1'b0;
        #1;
        chk("ready_after_rst", 72'(cfg_ready), 72'd1);

        // Non-sof bytes in IDLE are discarded, even if they look like a frame.
        for (int k = 0; k < 8; k++) put(8'hFF, 1'b0);
        put(8'h80, 1'b0);
        put(8'h80, 1'b0);
        idle(2);
        chk("idle_discard_done", 72'(done_cnt), 72'd0);
        chk("idle_discard_sram", 72'(sram), 72'h0);

        // Good frame: FF x8, 80, checksum 80
        send_frame({{8{8'hFF}}, 8'h80}, 8'h80, 1'b0);
        exp_commits++;
        chk("f1_done", 72'(cfg_done), 72'd1);
        chk("f1_ready_commit", 72'(cfg_ready), 72'd0);
        chk("f1_sram_not_yet", 72'(sram), 72'h0);
        idle(1);
        chk("f1_sram", 72'(sram), {8'h00, {64{1'b1}}});
        chk("f1_sram_inv", 72'(sram_inv), 72'h0);
        chk("f1_mode", 72'(mode), 72'd2);
        chk("f1_mode_inv", 72'(mode_inv), 72'd1);
        chk("f1_err", 72'(cfg_err), 72'd0);
        chk("f1_done_low", 72'(cfg_done), 72'd0);
        chk("f1_ready_back", 72'(cfg_ready), 72'd1);

        // Bad checksum: outputs are kept
        d0 = done_cnt;
        send_frame({{8{8'hFF}}, 8'h80}, 8'h81, 1'b0);
        chk("f2_err", 72'(cfg_err), 72'd1);
        chk("f2_done", 72'(cfg_done), 72'd0);
        idle(2);
        chk("f2_sram_kept", 72'(sram), {8'h00, {64{1'b1}}});
        chk("f2_mode_kept", 72'(mode), 72'd2);
        chk("f2_err_sticky", 72'(cfg_err), 72'd1);
        chk("f2_no_commit", 72'(done_cnt - d0), 72'd0);

        // Pad bit set, checksum consistent
        d0 = done_cnt;
        send_frame({{8{8'hFF}}, 8'h81}, 8'h81, 1'b0);
        chk("f3_err", 72'(cfg_err), 72'd1);
        chk("f3_done", 72'(cfg_done), 72'd0);
        idle(2);
        chk("f3_sram_kept", 72'(sram), {8'h00, {64{1'b1}}});
        chk("f3_mode_kept", 72'(mode), 72'd2);
        chk("f3_no_commit", 72'(done_cnt - d0), 72'd0);

        // sof in mid-frame after 5 bytes, then a full A5 frame
        d0 = done_cnt;
        put(8'h11, 1'b1);
        for (int k = 0; k < 4; k++) put(8'h11, 1'b0);
        send_frame({{8{8'hA5}}, 8'h40}, 8'h40, 1'b0);
        exp_commits++;
        chk("f4_done", 72'(cfg_done), 72'd1);
        idle(1);
        chk("f4_sram", 72'(sram), 72'h00A5A5A5A5A5A5A5A5);
        chk("f4_sram_inv", 72'(sram_inv), 72'h005A5A5A5A5A5A5A5A);
        chk("f4_mode", 72'(mode), 72'd1);
        chk("f4_mode_inv", 72'(mode_inv), 72'd2);
        chk("f4_err", 72'(cfg_err), 72'd0);
        chk("f4_single_commit", 72'(done_cnt - d0), 72'd1);

        // Back-to-back reference frame
        send_frame(72'h0123456789ABCDEFC0, 8'hC0, 1'b0);
        exp_commits++;
        idle(1);
        chk("f5_sram", 72'(sram), 72'h000123456789ABCDEF);
        chk("f5_mode", 72'(mode), 72'd3);

        // Change the outputs, then send the same frame with random gaps
        send_frame({{8{8'hFF}}, 8'h80}, 8'h80, 1'b0);
        exp_commits++;
        idle(1);
        chk("f6_sram", 72'(sram), {8'h00, {64{1'b1}}});
        send_frame(72'h0123456789ABCDEFC0, 8'hC0, 1'b1);
        exp_commits++;
        chk("f7_done", 72'(cfg_done), 72'd1);
        idle(1);
        chk("f7_sram", 72'(sram), 72'h000123456789ABCDEF);
        chk("f7_sram_inv", 72'(sram_inv), 72'h00FEDCBA9876543210);
        chk("f7_mode", 72'(mode), 72'd3);
        chk("f7_mode_inv", 72'(mode_inv), 72'd0);
        chk("f7_err", 72'(cfg_err), 72'd0);

        // Reset after byte 6 abandons the frame
        put(8'h77, 1'b1);
        for (int k = 0; k < 6; k++) put(8'h77, 1'b0);
        d0 = done_cnt;
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        chk("r_ready", 72'(cfg_ready), 72'd0);
        pReset = 1'b0;
        #1;
        chk("r_sram", 72'(sram), 72'h0);
        chk("r_sram_inv", 72'(sram_inv), {8'h00, {64{1'b1}}});
        chk("r_mode", 72'(mode), 72'd0);
        chk("r_mode_inv", 72'(mode_inv), 72'd3);
        chk("r_err", 72'(cfg_err), 72'd0);
        chk("r_ready_after", 72'(cfg_ready), 72'd1);
        // Bytes 7-9 of the abandoned frame must not complete anything.
        put(8'h77, 1'b0);
        put(8'h77, 1'b0);
        put(8'h77, 1'b0);
        idle(2);
        chk("r_no_commit", 72'(done_cnt - d0), 72'd0);
        send_frame({{8{8'hA5}}, 8'h40}, 8'h40, 1'b0);
        exp_commits++;
        idle(1);
        chk("r2_sram", 72'(sram), 72'h00A5A5A5A5A5A5A5A5);
        chk("r2_mode", 72'(mode), 72'd1);

        idle(2);
        chk("total_commits", 72'(done_cnt), 72'(exp_commits));
        chk("ready_low_cycles", 72'(rlow_cnt), 72'(exp_commits));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
